// File: rtl/tt_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tt_sweep_ctrl
//
// Characterises one 4-input combinational gate by stepping through all 16
// input patterns, holding each for SETTLE extra cycles, sampling the gate
// output, and building the measured 16-bit truth table. The table is compared
// bit by bit against an expected table latched at start.
//
// Parameters:
//   SETTLE    extra hold cycles per pattern before sampling (0..15)
//
// Ports:
//   clk       clock, all state changes on the rising edge
//   rst       synchronous reset, active high
//   start     sweep request, only honoured while idle
//   exp_tt    expected truth table, latched on the accepted start
//   pat       pattern to the gate (pat[3] -> input _0 ... pat[0] -> input _3)
//   gate_out  output of the gate under test
//   busy      high while patterns are being driven
//   done      one-cycle pulse, results valid from this cycle
//   tt        measured table, pattern i stored at bit 15-i
//   pass      measured table equals the latched expected table
//   err_cnt   number of mismatching bits (0..16)
//   first_err lowest mismatching pattern index, 0 when none
// -----------------------------------------------------------------------------
module tt_sweep_ctrl #(
    parameter int unsigned SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] exp_tt,
    output logic [3:0]  pat,
    input  logic        gate_out,
    output logic        busy,
    output logic        done,
    output logic [15:0] tt,
    output logic        pass,
    output logic [4:0]  err_cnt,
    output logic [3:0]  first_err
);

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

    state_t      state_r;
    logic [3:0]  idx_r;
    logic [3:0]  cnt_r;
    logic [15:0] exp_r;
    logic [3:0]  pat_r;
    logic        busy_r;
    logic        done_r;
    logic [15:0] tt_r;
    logic        pass_r;
    logic [4:0]  err_cnt_r;
    logic [3:0]  first_err_r;

    logic        mismatch_s;
    logic [4:0]  err_cnt_next_s;

    // Compare the sampled gate output against the expected bit for this pattern.
    always_comb begin
        mismatch_s     = 1'b0;
        err_cnt_next_s = err_cnt_r;
        if (gate_out != exp_r[4'd15 - idx_r]) begin
            mismatch_s     = 1'b1;
            err_cnt_next_s = err_cnt_r + 5'd1;
        end else begin
            mismatch_s     = 1'b0;
            err_cnt_next_s = err_cnt_r;
        end
    end

    // Sweep sequencer: state, pattern/hold counters and registered results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            idx_r       <= 4'd0;
            cnt_r       <= 4'd0;
            exp_r       <= 16'd0;
            pat_r       <= 4'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            tt_r        <= 16'd0;
            pass_r      <= 1'b0;
            err_cnt_r   <= 5'd0;
            first_err_r <= 4'd0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    pat_r  <= 4'd0;
                    busy_r <= 1'b0;
                    if (start) begin
                        exp_r       <= exp_tt;
                        idx_r       <= 4'd0;
                        cnt_r       <= SETTLE_C;
                        tt_r        <= 16'd0;
                        err_cnt_r   <= 5'd0;
                        first_err_r <= 4'd0;
                        pass_r      <= 1'b0;
                        busy_r      <= 1'b1;
                        state_r     <= ST_SETTLE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_r != 4'd0) begin
                        cnt_r <= cnt_r - 4'd1;
                    end else begin
                        // MSB-first shift leaves pattern i at bit 15-i after 16 samples.
                        tt_r      <= {tt_r[14:0], gate_out};
                        err_cnt_r <= err_cnt_next_s;
                        // A zero count before this sample means this is the first mismatch.
                        if (mismatch_s && (err_cnt_r == 5'd0)) begin
                            first_err_r <= idx_r;
                        end
                        if (idx_r == 4'd15) begin
                            // pass must already be valid in the done cycle, so use the
                            // count that includes this final sample.
                            pass_r  <= (err_cnt_next_s == 5'd0);
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                            pat_r   <= 4'd0;
                            state_r <= ST_REPORT;
                        end else begin
                            idx_r <= idx_r + 4'd1;
                            pat_r <= idx_r + 4'd1;
                            cnt_r <= SETTLE_C;
                        end
                    end
                end
                ST_REPORT: begin
                    busy_r  <= 1'b0;
                    pat_r   <= 4'd0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    pat_r   <= 4'd0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign pat       = pat_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign tt        = tt_r;
    assign pass      = pass_r;
    assign err_cnt   = err_cnt_r;
    assign first_err = first_err_r;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for tt_sweep_ctrl. Two instances: index 0 uses SETTLE=0, index 1 uses
// SETTLE=2. Both drive a gate model with truth table 0x429B. A cycle-offset
// model predicts busy/done/pat and the final results; literal checks pin the
// headline numbers.
// -----------------------------------------------------------------------------
module tb_tt_sweep_ctrl;

    logic        clk = 1'b0;
    logic [1:0]  rst_v = 2'b11;
    logic [1:0]  start_v = 2'b00;
    logic [15:0] exp_v [2];
    logic [3:0]  pat_w [2];
    logic [1:0]  gate_w;
    logic [1:0]  busy_w, done_w, pass_w;
    logic [15:0] tt_w [2];
    logic [4:0]  err_w [2];
    logic [3:0]  fe_w [2];

    logic [15:0] gate_tab = 16'h429B;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    // Gate under test: pattern i produces truth-table bit 15-i.
    assign gate_w[0] = gate_tab[4'd15 - pat_w[0]];
    assign gate_w[1] = gate_tab[4'd15 - pat_w[1]];

    tt_sweep_ctrl #(.SETTLE(0)) u_dut0 (
        .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .exp_tt(exp_v[0]),
        .pat(pat_w[0]), .gate_out(gate_w[0]), .busy(busy_w[0]), .done(done_w[0]),
        .tt(tt_w[0]), .pass(pass_w[0]), .err_cnt(err_w[0]), .first_err(fe_w[0])
    );

    tt_sweep_ctrl #(.SETTLE(2)) u_dut2 (
        .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .exp_tt(exp_v[1]),
        .pat(pat_w[1]), .gate_out(gate_w[1]), .busy(busy_w[1]), .done(done_w[1]),
        .tt(tt_w[1]), .pass(pass_w[1]), .err_cnt(err_w[1]), .first_err(fe_w[1])
    );

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s dut%0d: got %0h want %0h", nm, d, act, want);
        end
    endtask

    function automatic int settle_of(input int d);
        return (d == 0) ? 0 : 2;
    endfunction

    // ---------------- behavioural model ----------------
    int          cyc = 0;
    bit          act [2];
    int          t0 [2];
    logic [15:0] m_tt [2];
    logic        m_pass [2];
    logic [4:0]  m_err [2];
    logic [3:0]  m_fe [2];
    int          done_cnt [2];
    int          last_done [2];

    // Advance the model on each edge using the inputs sampled at that edge.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int len;
            len = 16 * (settle_of(d) + 1);
            if (rst_v[d]) begin
                act[d] = 1'b0; m_tt[d] = 16'd0; m_pass[d] = 1'b0; m_err[d] = 5'd0; m_fe[d] = 4'd0;
            end else if (start_v[d] && (!act[d] || (cyc - t0[d]) >= len + 2)) begin
                int ne; int fe;
                ne = 0; fe = -1;
                for (int i = 0; i < 16; i++) begin
                    if (gate_tab[15 - i] != exp_v[d][15 - i]) begin
                        ne++;
                        if (fe < 0) fe = i;
                    end
                end
                act[d] = 1'b1; t0[d] = cyc;
                m_tt[d] = gate_tab; m_err[d] = 5'(ne); m_pass[d] = (ne == 0);
                m_fe[d] = (fe < 0) ? 4'd0 : 4'(fe);
            end
        end
        cyc++;
    end

    // Single compare process: outputs against the model every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                int k; int s1; bit busy_e; bit done_e; int pat_e;
                s1 = settle_of(d) + 1;
                k = cyc - t0[d];
                busy_e = act[d] && k >= 1 && k <= 16 * s1;
                done_e = act[d] && k == 16 * s1 + 1;
                pat_e = busy_e ? (k - 1) / s1 : 0;
                chk("busy", d, 32'(busy_w[d]), 32'(busy_e));
                chk("done", d, 32'(done_w[d]), 32'(done_e));
                if (!done_e) chk("pat", d, 32'(pat_w[d]), 32'(pat_e));
                if (!busy_e) begin
                    chk("tt", d, 32'(tt_w[d]), 32'(m_tt[d]));
                    chk("pass", d, 32'(pass_w[d]), 32'(m_pass[d]));
                    chk("err_cnt", d, 32'(err_w[d]), 32'(m_err[d]));
                    chk("first_err", d, 32'(fe_w[d]), 32'(m_fe[d]));
                end
                if (done_w[d] === 1'b1) begin
                    done_cnt[d]++;
                    last_done[d] = cyc;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Run one SETTLE=2 sweep and pin latency and results to hand values.
    task automatic sweep2(input logic [15:0] e, input logic [15:0] tt_l, input logic pass_l,
                          input logic [4:0] err_l, input logic [3:0] fe_l);
        int n;
        start_v[1] = 1'b1; exp_v[1] = e;
        tick(1);
        start_v[1] = 1'b0;
        n = 1;
        while (done_w[1] !== 1'b1 && n < 200) begin
            tick(1);
            n++;
        end
        chk("done_latency", 1, 32'(n), 32'd49);
        chk("lit_tt", 1, 32'(tt_w[1]), 32'(tt_l));
        chk("lit_pass", 1, 32'(pass_w[1]), 32'(pass_l));
        chk("lit_err_cnt", 1, 32'(err_w[1]), 32'(err_l));
        chk("lit_first_err", 1, 32'(fe_w[1]), 32'(fe_l));
        tick(3);
    endtask

    initial begin
        int cs; int n; int dn;
        exp_v[0] = 16'd0; exp_v[1] = 16'd0;
        for (int d = 0; d < 2; d++) begin
            act[d] = 1'b0; t0[d] = 0; m_tt[d] = 16'd0; m_pass[d] = 1'b0;
            m_err[d] = 5'd0; m_fe[d] = 4'd0; done_cnt[d] = 0; last_done[d] = 0;
        end

        // Reset for two cycles, then ten idle cycles checked by the model.
        tick(2);
        rst_v = 2'b00;
        chk_en = 1'b1;
        tick(10);
        chk("lit_reset_tt", 1, 32'(tt_w[1]), 32'd0);

        // SETTLE=2 sweeps: nominal, single mismatch, full mismatch.
        sweep2(16'h429B, 16'h429B, 1'b1, 5'd0,  4'd0);
        sweep2(16'h429A, 16'h429B, 1'b0, 5'd1,  4'd15);
        sweep2(16'hBD64, 16'h429B, 1'b0, 5'd16, 4'd0);

        // Reset while pattern 7 is on the gate.
        start_v[1] = 1'b1; exp_v[1] = 16'h429B;
        tick(1);
        start_v[1] = 1'b0;
        n = 0;
        while (pat_w[1] !== 4'd7 && n < 100) begin
            tick(1);
            n++;
        end
        chk("reach_pat7", 1, 32'(pat_w[1]), 32'd7);
        dn = done_cnt[1];
        rst_v[1] = 1'b1;
        tick(1);
        rst_v[1] = 1'b0;
        chk("rst_busy", 1, 32'(busy_w[1]), 32'd0);
        chk("rst_pat", 1, 32'(pat_w[1]), 32'd0);
        chk("rst_tt", 1, 32'(tt_w[1]), 32'd0);
        tick(60);
        chk("rst_no_done", 1, 32'(done_cnt[1]), 32'(dn));
        sweep2(16'h429B, 16'h429B, 1'b1, 5'd0, 4'd0);

        // SETTLE=0 protocol: restart pulse and exp_tt change mid-sweep.
        dn = done_cnt[0];
        cs = cyc;
        start_v[0] = 1'b1; exp_v[0] = 16'h429B;
        tick(1);
        start_v[0] = 1'b0;
        tick(4);
        start_v[0] = 1'b1;
        tick(1);
        start_v[0] = 1'b0; exp_v[0] = 16'h0000;
        tick(30);
        chk("proto_one_done", 0, 32'(done_cnt[0] - dn), 32'd1);
        chk("proto_done_cycle", 0, 32'(last_done[0] - cs), 32'd17);
        chk("proto_pass", 0, 32'(pass_w[0]), 32'd1);
        chk("proto_tt", 0, 32'(tt_w[0]), 32'h429B);

        // Held-high start: next busy rises two cycles after done.
        dn = done_cnt[0];
        exp_v[0] = 16'h429B;
        start_v[0] = 1'b1;
        n = 0;
        while (done_cnt[0] == dn && n < 100) begin
            tick(1);
            n++;
        end
        chk("held_first_done", 0, 32'(done_cnt[0] - dn), 32'd1);
        dn = last_done[0];
        n = 0;
        while (busy_w[0] !== 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        chk("held_busy_gap", 0, 32'(cyc - dn), 32'd2);
        start_v[0] = 1'b0;
        tick(40);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
